// File: rtl/wb2uart_if.sv
// -----------------------------------------------------------------------------
// wb2uart_if
// Local Wishbone bus between a master (CPU / host logic) and the wb2uart bridge.
//
// Signals:
//   i_wb_stb, i_wb_cyc  request strobe / cycle qualifier (master -> bridge)
//   i_wb_rw             1 = read, 0 = write
//   i_wb_addr[23:0]     target address on the remote bus
//   i_wb_dat[7:0]       write data
//   o_wb_dat[7:0]       read data, valid while o_wb_ack is high
//   o_wb_ack            one-cycle completion pulse
//   o_wb_err            one-cycle error pulse (read timeout / bad reply char)
//
// Handshake: a request is taken when stb & cyc are both high while the bridge
// is idle. The master holds stb/cyc (and addr/rw/dat) until it sees exactly one
// of ack or err for one cycle, then drops them; the bridge will not accept a
// new request in the same cycle as that ack/err pulse.
// -----------------------------------------------------------------------------
interface wb2uart_if;
  logic        i_wb_stb;
  logic        i_wb_cyc;
  logic        i_wb_rw;
  logic [23:0] i_wb_addr;
  logic [7:0]  i_wb_dat;
  logic [7:0]  o_wb_dat;
  logic        o_wb_ack;
  logic        o_wb_err;

  modport slave (
    input  i_wb_stb, i_wb_cyc, i_wb_rw, i_wb_addr, i_wb_dat,
    output o_wb_dat, o_wb_ack, o_wb_err
  );

  modport master (
    output i_wb_stb, i_wb_cyc, i_wb_rw, i_wb_addr, i_wb_dat,
    input  o_wb_dat, o_wb_ack, o_wb_err
  );
endinterface

// File: rtl/wb2uart.sv
// -----------------------------------------------------------------------------
// wb2uart
// Bridges local Wishbone cycles (24-bit address, 8-bit data) onto a UART byte
// stream in the ASCII command language of the remote UART-to-Wishbone bridge:
//   '.'            resynchronise the remote parser
//   'p' + 6 hex    load remote address (byte order [7:0],[15:8],[23:16])
//   'w' + 2 hex    write data, remote address auto-increments
//   'r'            read, remote replies with 2 hex characters
// The remote address is cached so consecutive accesses skip the 'p' command.
//
// Ports:
//   i_wb_clk, i_wb_rst_n  clock, asynchronous active-low reset
//   wb                    Wishbone slave side (see wb2uart_if)
//   tx_dat, send          character + one-cycle request to the UART transmitter
//   tx_busy               transmitter busy
//   rx_dat, received      character + one-cycle valid from the UART receiver
//   dbg_state             current FSM state
// -----------------------------------------------------------------------------
module wb2uart #(
  parameter int TIMEOUT = 100000
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst_n,
  wb2uart_if.slave    wb,
  output logic [7:0]  tx_dat,
  output logic        send,
  input  logic        tx_busy,
  input  logic [7:0]  rx_dat,
  input  logic        received,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    CMD_P  = 3'd2,
    ADDR   = 3'd3,
    CMD_RW = 3'd4,
    WDATA  = 3'd5,
    RDATA  = 3'd6
  } state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state, state_d;
  logic          guard;         // high in the cycle after a send: tx_busy not yet trustworthy
  logic [2:0]    nib_idx;       // character index inside ADDR / WDATA
  logic [23:0]   lat_addr;
  logic          lat_rw;
  logic [7:0]    lat_dat;
  logic          sync_needed;
  logic          addr_valid;
  logic [23:0]   remote_addr;   // our copy of the remote bridge's address register
  logic [3:0]    rx_hi;
  logic          rx_have_hi;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    rd_dat_q;
  logic          ack_q;
  logic          err_q;

  logic          accept;
  logic          tx_ok;
  logic          want_tx;
  logic [7:0]    tx_char;
  logic [3:0]    tx_nib;
  logic          rx_valid;
  logic [3:0]    rx_nib;
  logic          rx_done;
  logic          rx_fail;

  function automatic logic [7:0] hex_enc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Returns {valid, nibble}; only '0'-'9' and upper-case 'A'-'F' are accepted.
  function automatic logic [4:0] hex_dec(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)      return {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46) return {1'b1, c[3:0] + 4'd9};
    else                               return 5'd0;
  endfunction

  assign wb.o_wb_dat = rd_dat_q;
  assign wb.o_wb_ack = ack_q;
  assign wb.o_wb_err = err_q;
  assign dbg_state   = state;

  // ---------------------------------------------------------------------------
  // Next state / outputs. send is combinational so it reacts to tx_busy in the
  // same cycle it is observed; the guard cycle covers the transmitter's delay
  // in raising tx_busy after accepting a character.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    want_tx = 1'b0;
    tx_char = 8'h00;
    rx_done = 1'b0;
    rx_fail = 1'b0;
    tx_ok   = !guard && !tx_busy;
    {rx_valid, rx_nib} = hex_dec(rx_dat);

    case (nib_idx)
      3'd0:    tx_nib = lat_addr[7:4];
      3'd1:    tx_nib = lat_addr[3:0];
      3'd2:    tx_nib = lat_addr[15:12];
      3'd3:    tx_nib = lat_addr[11:8];
      3'd4:    tx_nib = lat_addr[23:20];
      default: tx_nib = lat_addr[19:16];
    endcase

    case (state)
      IDLE: begin
        // Requests are ignored while ack/err is still visible to the master.
        if (wb.i_wb_stb && wb.i_wb_cyc && !ack_q && !err_q) begin
          accept = 1'b1;
          if (sync_needed)                                      state_d = SYNC;
          else if (!addr_valid || wb.i_wb_addr != remote_addr) state_d = CMD_P;
          else                                                  state_d = CMD_RW;
        end
      end
      SYNC: begin
        want_tx = 1'b1;
        tx_char = 8'h2E;
        if (tx_ok) state_d = CMD_P;
      end
      CMD_P: begin
        want_tx = 1'b1;
        tx_char = 8'h70;
        if (tx_ok) state_d = ADDR;
      end
      ADDR: begin
        want_tx = 1'b1;
        tx_char = hex_enc(tx_nib);
        if (tx_ok && nib_idx == 3'd5) state_d = CMD_RW;
      end
      CMD_RW: begin
        want_tx = 1'b1;
        tx_char = lat_rw ? 8'h72 : 8'h77;
        if (tx_ok) state_d = lat_rw ? RDATA : WDATA;
      end
      WDATA: begin
        want_tx = 1'b1;
        tx_char = hex_enc(nib_idx[0] ? lat_dat[3:0] : lat_dat[7:4]);
        if (tx_ok && nib_idx[0]) state_d = IDLE;
      end
      RDATA: begin
        if (received) begin
          if (!rx_valid) begin
            rx_fail = 1'b1;
            state_d = IDLE;
          end else if (rx_have_hi) begin
            rx_done = 1'b1;
            state_d = IDLE;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          rx_fail = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    send   = want_tx && tx_ok;
    tx_dat = send ? tx_char : 8'h00;
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) state <= IDLE;
    else             state <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      guard       <= 1'b0;
      nib_idx     <= 3'd0;
      lat_addr    <= 24'h0;
      lat_rw      <= 1'b0;
      lat_dat     <= 8'h0;
      sync_needed <= 1'b1;
      addr_valid  <= 1'b0;
      remote_addr <= 24'h0;
      rx_hi       <= 4'h0;
      rx_have_hi  <= 1'b0;
      tmo_cnt     <= '0;
      rd_dat_q    <= 8'h0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      guard <= send;
      ack_q <= 1'b0;
      err_q <= 1'b0;

      if (accept) begin
        lat_addr <= wb.i_wb_addr;
        lat_rw   <= wb.i_wb_rw;
        lat_dat  <= wb.i_wb_dat;
      end

      if (state_d != state) nib_idx <= 3'd0;
      else if (send)        nib_idx <= nib_idx + 3'd1;

      if (state == SYNC && send) sync_needed <= 1'b0;

      if (state == ADDR && send && nib_idx == 3'd5) begin
        remote_addr <= lat_addr;
        addr_valid  <= 1'b1;
      end

      if (state == WDATA && send && nib_idx[0]) begin
        remote_addr <= remote_addr + 24'd1;
        ack_q       <= 1'b1;
      end

      // Timeout restarts on entry to RDATA and after every received char.
      if (state != RDATA || received) tmo_cnt <= '0;
      else                            tmo_cnt <= tmo_cnt + 1'b1;

      if (state != RDATA) begin
        rx_have_hi <= 1'b0;
      end else if (received && rx_valid && !rx_have_hi) begin
        rx_hi      <= rx_nib;
        rx_have_hi <= 1'b1;
      end

      if (rx_done) begin
        rd_dat_q    <= {rx_hi, rx_nib};
        ack_q       <= 1'b1;
        remote_addr <= remote_addr + 24'd1;
      end

      // After a failed read the remote parser state is unknown: resync and
      // reload the address on the next access.
      if (rx_fail) begin
        rd_dat_q    <= 8'hFF;
        err_q       <= 1'b1;
        addr_valid  <= 1'b0;
        sync_needed <= 1'b1;
      end
    end
  end

endmodule
